// File: rtl/shiftdn_pkg.sv
// Shared definitions for the SHIFTDN chain controller.
//
// A SHIFTDN instruction is a 134-bit word laid out as
//   {vld[133], data[132:5], smc_id[4:0]}
// The same layout is used for the instruction injected into stage 0 and for
// every stage output tap that the controller samples.
package shiftdn_pkg;

  localparam int unsigned CRD_W  = 134;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned ID_W   = 5;

  localparam int unsigned VLD_BIT  = 133;
  localparam int unsigned DATA_MSB = 132;
  localparam int unsigned DATA_LSB = 5;
  localparam int unsigned ID_MSB   = 4;

  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   smc_id;
  } crd_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  // Instruction injected at the head of the chain: valid, empty payload, target ID.
  function automatic crd_t make_shiftdn(input logic [ID_W-1:0] smc_id);
    crd_t c;
    c.vld    = 1'b1;
    c.data   = '0;
    c.smc_id = smc_id;
    return c;
  endfunction

endpackage

// File: rtl/shiftdn_tap_mux.sv
// NUM_SMC:1 selector of one 134-bit stage output tap.
//
// Ports:
//   taps_i  flattened stage outputs, tap k at [k*CRD_W +: CRD_W]
//   sel_i   stage index to select
//   tap_o   selected tap; all-zero when sel_i does not name an existing stage
//
// Purely combinational so it can be shared with a debug readout path.
module shiftdn_tap_mux
  import shiftdn_pkg::*;
#(
  parameter int unsigned NUM_SMC = 8
) (
  input  logic [NUM_SMC*CRD_W-1:0] taps_i,
  input  logic [ID_W-1:0]          sel_i,
  output logic [CRD_W-1:0]         tap_o
);

  always_comb begin
    tap_o = '0;
    for (int k = 0; k < int'(NUM_SMC); k++) begin
      if (sel_i == ID_W'(k)) begin
        tap_o = taps_i[k*CRD_W +: CRD_W];
      end
    end
  end

endmodule

// File: rtl/shiftdn_ctrl.sv
// Initiator and collector for the SHIFTDN chain of per-SMC shift-down stages.
//
// A host read request names one SMC. The controller injects a single-cycle
// SHIFTDN instruction into stage 0, waits the fixed propagation latency to
// the addressed stage, samples that stage's tap and returns its data word on
// a valid/ready response channel. rsp_err_o flags an illegal ID (no
// instruction issued) or a tap whose vld/ID fields do not match the request.
//
// Ports:
//   clk               clock
//   rst_n             asynchronous active-low reset
//   req_vld_i         host request valid (host holds it until accepted)
//   req_rdy_o         high while idle; a request is accepted when both are high
//   req_smc_id_i      target SMC ID
//   crd_shiftdn_out_o instruction to stage 0 (single-cycle vld pulse)
//   crd_tap_in_i      flattened stage outputs, tap k at [k*134 +: 134]
//   rsp_vld_o         response valid
//   rsp_rdy_i         host accepts response
//   rsp_data_o        sampled data word
//   rsp_err_o         illegal ID or tap check failure
//
// Latency from request acceptance to rsp_vld_o is id+3 cycles for a legal
// ID and 1 cycle for an illegal one.
module shiftdn_ctrl
  import shiftdn_pkg::*;
#(
  parameter int unsigned NUM_SMC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld_i,
  output logic                     req_rdy_o,
  input  logic [ID_W-1:0]          req_smc_id_i,
  output logic [CRD_W-1:0]         crd_shiftdn_out_o,
  input  logic [NUM_SMC*CRD_W-1:0] crd_tap_in_i,
  output logic                     rsp_vld_o,
  input  logic                     rsp_rdy_i,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     rsp_err_o
);

  // One extra bit so NUM_SMC=32 is representable in the ID range check.
  localparam logic [ID_W:0] NumSmcW = (ID_W + 1)'(NUM_SMC);

  state_e             state_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    cnt_q;
  logic [CRD_W-1:0]   crd_q;
  logic               rsp_vld_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;

  logic [CRD_W-1:0]   tap_sel;
  crd_t               tap_crd;

  shiftdn_tap_mux #(
    .NUM_SMC (NUM_SMC)
  ) u_tap_mux (
    .taps_i (crd_tap_in_i),
    .sel_i  (id_q),
    .tap_o  (tap_sel)
  );

  assign tap_crd = crd_t'(tap_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      id_q       <= '0;
      cnt_q      <= '0;
      crd_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_vld_i) begin
            id_q <= req_smc_id_i;
            if ({1'b0, req_smc_id_i} >= NumSmcW) begin
              // No such stage: answer immediately without touching the chain.
              rsp_vld_q  <= 1'b1;
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
              state_q    <= StResp;
            end else begin
              crd_q   <= make_shiftdn(req_smc_id_i);
              state_q <= StIssue;
            end
          end
        end

        StIssue: begin
          // Drop vld after one cycle; stage 0 holds its captured copy.
          crd_q   <= '0;
          cnt_q   <= '0;
          state_q <= StWait;
        end

        StWait: begin
          // Stage k shows the fresh result exactly when cnt_q == k; earlier
          // cycles may still show sticky content from a previous request.
          if (cnt_q == id_q) begin
            rsp_vld_q  <= 1'b1;
            rsp_data_q <= tap_crd.data;
            rsp_err_q  <= !(tap_crd.vld && (tap_crd.smc_id == id_q));
            state_q    <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        StResp: begin
          // Data and error flag keep their value after the handshake.
          if (rsp_rdy_i) begin
            rsp_vld_q <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_rdy_o         = (state_q == StIdle);
  assign crd_shiftdn_out_o = crd_q;
  assign rsp_vld_o         = rsp_vld_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_err_o         = rsp_err_q;

endmodule

// File: tb/tb_shiftdn_ctrl.sv
// Bench for shiftdn_ctrl: an 8-stage behavioural shift-down chain, where
// stage k (SMC_ID=k) owns data 128'hA000_0000 + k, driven by the controller's
// instruction output. Table-driven request vectors plus hand-written
// sequences for response back-pressure, a corrupted tap and mid-flight reset.
module tb_shiftdn_ctrl;

  localparam int unsigned NSMC = 8;
  localparam int unsigned CW   = 134;

  logic                 clk;
  logic                 rst_n;
  logic                 req_vld;
  logic                 req_rdy;
  logic [4:0]           req_smc_id;
  logic [CW-1:0]        crd_out;
  logic [NSMC*CW-1:0]   taps;
  logic                 rsp_vld;
  logic                 rsp_rdy;
  logic [127:0]         rsp_data;
  logic                 rsp_err;

  int n_vec;
  int n_err;

  shiftdn_ctrl #(
    .NUM_SMC (NSMC)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_vld_i         (req_vld),
    .req_rdy_o         (req_rdy),
    .req_smc_id_i      (req_smc_id),
    .crd_shiftdn_out_o (crd_out),
    .crd_tap_in_i      (taps),
    .rsp_vld_o         (rsp_vld),
    .rsp_rdy_i         (rsp_rdy),
    .rsp_data_o        (rsp_data),
    .rsp_err_o         (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural chain: a stage captures its input whenever input vld is set,
  // substituting its own data when the ID matches, otherwise passing through.
  logic [CW-1:0] stage_q [NSMC];
  logic [CW-1:0] stage_in [NSMC];
  logic          force_en;
  logic [4:0]    force_id;

  always_comb begin
    stage_in[0] = crd_out;
    for (int k = 1; k < int'(NSMC); k++) stage_in[k] = stage_q[k-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NSMC); k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NSMC); k++) begin
        if (stage_in[k][133]) begin
          if (stage_in[k][4:0] == 5'(k))
            stage_q[k] <= {1'b1, 128'(128'hA000_0000 + 128'(k)), 5'(k)};
          else
            stage_q[k] <= stage_in[k];
        end
      end
    end
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k < int'(NSMC); k++) taps[k*CW +: CW] = stage_q[k];
    if (force_en) taps[4*CW +: 5] = force_id;
  end

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and collect its response. With hold > 0 the response is
  // back-pressured for that many cycles while a second request is presented.
  task automatic run_req(input logic [4:0] id, input int hold, output int lat,
                         output logic [127:0] data, output logic err, output int pulses);
    @(negedge clk);
    chk("req_rdy_idle", CW'(req_rdy), CW'(1));
    req_vld    = 1'b1;
    req_smc_id = id;
    rsp_rdy    = 1'b0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    lat     = 1;
    pulses  = 0;
    while (!rsp_vld && lat < 60) begin
      if (crd_out[133]) pulses++;
      @(posedge clk); #1;
      lat++;
    end
    data = rsp_data;
    err  = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      req_vld    = 1'b1;
      req_smc_id = 5'd1;
      @(posedge clk); #1;
      chk("hold_vld", CW'(rsp_vld), CW'(1));
      chk("hold_data", CW'(rsp_data), CW'(data));
      chk("hold_rdy", CW'(req_rdy), CW'(0));
      chk("hold_no_issue", CW'(crd_out[133]), CW'(0));
    end
    @(negedge clk);
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk("rsp_drop", CW'(rsp_vld), CW'(0));
    chk("rsp_data_keep", CW'(rsp_data), CW'(data));
  endtask

  typedef struct {
    logic [4:0]   id;
    int           hold;
    int           lat;
    logic [127:0] data;
    logic         err;
    int           pulses;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int           lat;
    logic [127:0] d;
    logic         e;
    int           p;
    int           seen;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_vld = 1'b0;
    req_smc_id = '0;
    rsp_rdy = 1'b0;
    force_en = 1'b0;
    force_id = '0;

    vecs[0] = '{5'd3,  0, 6,  128'hA000_0003, 1'b0, 1};
    vecs[1] = '{5'd0,  0, 3,  128'hA000_0000, 1'b0, 1};
    vecs[2] = '{5'd7,  0, 10, 128'hA000_0007, 1'b0, 1};
    vecs[3] = '{5'd2,  0, 5,  128'hA000_0002, 1'b0, 1};
    vecs[4] = '{5'd9,  0, 1,  128'h0,         1'b1, 0};
    vecs[5] = '{5'd8,  0, 1,  128'h0,         1'b1, 0};
    vecs[6] = '{5'd31, 0, 1,  128'h0,         1'b1, 0};
    vecs[7] = '{5'd5,  5, 8,  128'hA000_0005, 1'b0, 1};
    vecs[8] = '{5'd1,  0, 4,  128'hA000_0001, 1'b0, 1};

    repeat (2) @(negedge clk);
    chk("rst_req_rdy", CW'(req_rdy), CW'(1));
    chk("rst_crd", crd_out, CW'(0));
    chk("rst_rsp_vld", CW'(rsp_vld), CW'(0));
    chk("rst_rsp_data", CW'(rsp_data), CW'(0));
    chk("rst_rsp_err", CW'(rsp_err), CW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Exact instruction word for the first request while it is on the wire.
    @(negedge clk);
    req_vld = 1'b1;
    req_smc_id = 5'd3;
    @(posedge clk); #1;
    req_vld = 1'b0;
    chk("crd_word", crd_out, {1'b1, 128'h0, 5'd3});
    @(posedge clk); #1;
    chk("crd_pulse_end", crd_out, CW'(0));
    repeat (4) @(posedge clk);
    #1;
    chk("first_rsp_vld", CW'(rsp_vld), CW'(1));
    chk("first_rsp_data", CW'(rsp_data), CW'(128'hA000_0003));
    @(negedge clk);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].id, vecs[i].hold, lat, d, e, p);
      chk($sformatf("lat[%0d]", i), CW'(lat), CW'(vecs[i].lat));
      chk($sformatf("data[%0d]", i), CW'(d), CW'(vecs[i].data));
      chk($sformatf("err[%0d]", i), CW'(e), CW'(vecs[i].err));
      chk($sformatf("pulses[%0d]", i), CW'(p), CW'(vecs[i].pulses));
    end

    // Tap 4 reports the wrong ID: data still returned, error flagged.
    force_en = 1'b1;
    force_id = 5'd2;
    run_req(5'd4, 0, lat, d, e, p);
    chk("badtap_lat", CW'(lat), CW'(7));
    chk("badtap_err", CW'(e), CW'(1));
    chk("badtap_data", CW'(d), CW'(128'hA000_0004));
    force_en = 1'b0;

    // Reset in the middle of WAIT for id=6 aborts the request.
    @(negedge clk);
    req_vld = 1'b1;
    req_smc_id = 5'd6;
    @(posedge clk); #1;
    req_vld = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_crd", crd_out, CW'(0));
    chk("abort_rsp_vld", CW'(rsp_vld), CW'(0));
    chk("abort_rsp_data", CW'(rsp_data), CW'(0));
    chk("abort_rsp_err", CW'(rsp_err), CW'(0));
    chk("abort_req_rdy", CW'(req_rdy), CW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (rsp_vld || crd_out[133]) seen++;
    end
    chk("abort_no_rsp", CW'(seen), CW'(0));
    chk("abort_rdy_after", CW'(req_rdy), CW'(1));

    // Controller is usable again after the abort.
    run_req(5'd6, 0, lat, d, e, p);
    chk("post_lat", CW'(lat), CW'(9));
    chk("post_data", CW'(d), CW'(128'hA000_0006));
    chk("post_err", CW'(e), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shiftdn_ctrl.md
Name: shiftdn_ctrl

Overview:
- Initiator and collector for the SHIFTDN chain of per-SMC shift-down stages.
- Accepts a host read request for one SMC ID, injects a 134-bit SHIFTDN instruction into the head of the chain (stage 0), and waits the fixed propagation latency.
- Samples the matching stage's output tap and returns its 128-bit data word on a valid/ready response channel, with an error flag.

Parameters:
- NUM_SMC, 8, number of chain stages (1..32); stage k has SMC_ID=k and tap k.
- CRD_W, 134, instruction width: {vld[133], data[132:5], smc_id[4:0]}.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- req_vld  input  1  host request valid.
- req_rdy  output  1  controller ready to accept a request.
- req_smc_id  input  5  target SMC ID.
- crd_shiftdn_out  output  134  instruction to stage 0.
- crd_tap_in  input  NUM_SMC*134  flattened stage outputs; tap k is bits [k*134+133 : k*134].
- rsp_vld  output  1  response valid.
- rsp_rdy  input  1  host accepts response.
- rsp_data  output  128  sampled data.
- rsp_err  output  1  illegal ID or tap check failure.

Behaviour:
- Reset values: state=IDLE, crd_shiftdn_out=0, rsp_vld=0, rsp_data=0, rsp_err=0, cnt=0, id_q=0. req_rdy is 1 out of reset, since it follows state IDLE.
- All outputs are registered, except req_rdy = (state==IDLE).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - On req_vld, latch id_q=req_smc_id.
  - If req_smc_id >= NUM_SMC: go to RESP with rsp_err=1 and rsp_data=0. No instruction is issued.
  - Otherwise: go to ISSUE and register crd_shiftdn_out={1'b1,128'b0,req_smc_id}.
- ISSUE (exactly 1 cycle, called T0):
  - crd_shiftdn_out holds the instruction.
  - On the next edge, crd_shiftdn_out returns to 0 and the FSM moves to WAIT with cnt=0.
  - The output is therefore a single-cycle vld pulse. Stage 0 holds its value while its input vld=0.
- WAIT:
  - cnt increments each cycle. Stage k's output is visible in cycle T0+k+1, i.e. when cnt==k.
  - When cnt==id_q, sample tap[id_q] and register into the response:
    - rsp_data = tap[132:5].
    - rsp_err = !(tap[133]==1 && tap[4:0]==id_q).
    - rsp_vld = 1, then go to RESP.
  - Total latency from request acceptance to rsp_vld is id_q+3 cycles.
- RESP:
  - rsp_vld, rsp_data and rsp_err stay stable while rsp_vld && !rsp_rdy.
  - On rsp_rdy: rsp_vld=0 on the next edge and the FSM returns to IDLE. rsp_data and rsp_err keep their last value.
  - rsp_rdy asserted in the same cycle rsp_vld rises is a valid handshake.
- Only one request is outstanding at a time. req_vld outside IDLE is ignored; the host must hold it.
- Sticky stage contents from earlier requests are not cleared. The fixed-latency sample guarantees the fresh value is read because stage id_q recaptures its data on the cycle the new instruction arrives.
- Upper stages continue holding or recapturing after sampling; this is harmless.
- Reset asserted mid-operation (any state) aborts immediately to the reset values. No response is produced for the aborted request.
- cnt is 5 bits and never wraps, because id_q <= 31.

Decomposition:
- Package shiftdn_pkg holds:
  - CRD_W=134, DATA_W=128, ID_W=5.
  - Field positions VLD_BIT=133, DATA_MSB=132, DATA_LSB=5, ID_MSB=4.
  - The FSM state enum.
- One sub-module, shiftdn_tap_mux: a combinational NUM_SMC:1 selector of a 134-bit tap by id_q. It is reused by a future debug readout.

Test Plan (chain of 8 shift_down stages; stage k's dvr_shiftdn_in = 128'hA000_0000 + k):
- Request id=3 after reset:
  - req_rdy=1 in IDLE.
  - crd_shiftdn_out = {1,0,5'd3} for exactly 1 cycle.
  - rsp_vld 6 cycles after acceptance, rsp_data=128'hA000_0003, rsp_err=0.
- Requests id=0, then id=7, then id=2 back-to-back:
  - Latencies are 3, 10 and 5 cycles.
  - Data is ...A000_0000, ...A000_0007, ...A000_0002; no stale data.
- Request id=9 with NUM_SMC=8:
  - No crd vld pulse.
  - rsp_vld 1 cycle after acceptance, rsp_err=1, rsp_data=0.
- Hold rsp_rdy=0 for 5 cycles during RESP:
  - rsp_vld stays 1 with unchanged data.
  - req_rdy stays 0.
  - A second req_vld is not accepted until after the handshake.
- Force tap 4 id field to 5'd2 and request id=4:
  - rsp_err=1, rsp_vld at cycle 7.
- Assert rst_n=0 in WAIT during an id=6 request:
  - All outputs go to 0 asynchronously.
  - After release, req_rdy=1 and no rsp_vld appears.
